sram_image_loader: RTL and testbench

- Fills the external SRAM with the packed image set (map, players, bullets, captions, backgrounds) before the game starts.
- Consumes a byte stream from the host link. Each byte holds two 4-bit pixels. The block packs two bytes into one 16-bit word and writes the words to sequential SRAM addresses with a fixed 3-cycle async-SRAM write sequence.
- Sits directly upstream of the SRAM arbiter/read path, which later fetches these words for display.

---
 rtl/sram_image_loader.sv | 152 +++++++++++++++
 tb/tb_sram_image_loader.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_image_loader.sv
// Packs host byte pairs into 16-bit words and writes them to sequential async-SRAM addresses.
// Optional running word checksum on o_checksum when LOADER_CHECKSUM_EN is defined.
module sram_image_loader #(
  parameter int ADDR_WIDTH = 20,
  parameter int DATA_WIDTH = 16,
  parameter int START_ADDR = 0,
  parameter int LOAD_WORDS = 739358
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_start,
  input  logic                  i_byte_valid,
  input  logic [7:0]            i_byte,
  output logic                  o_byte_ready,
  output logic [ADDR_WIDTH-1:0] o_sram_addr,
  output logic [DATA_WIDTH-1:0] o_sram_wdata,
  output logic                  o_sram_we_n,
  output logic                  o_sram_ce_n,
  output logic                  o_sram_oe_n,
  output logic                  o_sram_lb_n,
  output logic                  o_sram_ub_n,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [ADDR_WIDTH-1:0] o_word_count,
  output logic [15:0]           o_checksum,
  output logic [2:0]            o_dbg_state
);

  if (LOAD_WORDS == 0) begin : g_bad_load_words
    $error("sram_image_loader: LOAD_WORDS must be non-zero");
  end
  if (DATA_WIDTH != 16) begin : g_bad_data_width
    $error("sram_image_loader: DATA_WIDTH must be 16");
  end

  localparam logic [ADDR_WIDTH-1:0] START_A    = ADDR_WIDTH'(START_ADDR);
  localparam logic [ADDR_WIDTH-1:0] LAST_COUNT = ADDR_WIDTH'(LOAD_WORDS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_RECV_HI, S_RECV_LO, S_WR_SETUP, S_WR_PULSE, S_WR_HOLD, S_DONE
  } state_t;

  state_t                r_state;
  state_t                w_next_state;
  logic                  r_byte_ready;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic                  r_we_n;
  logic                  r_ce_n;
  logic                  r_oe_n;
  logic                  r_lb_n;
  logic                  r_ub_n;
  logic                  r_busy;
  logic                  r_done;
  logic [ADDR_WIDTH-1:0] r_word_count;
  logic                  w_handshake;
  logic                  w_last_word;

  // Valid/ready: a byte moves on a rising edge where i_byte_valid and o_byte_ready
  // are both high; the source must hold the byte stable until that edge.
  assign w_handshake = i_byte_valid & r_byte_ready;
  assign w_last_word = (r_word_count == LAST_COUNT);

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:     if (i_start) w_next_state = S_RECV_HI;
      S_RECV_HI:  if (w_handshake) w_next_state = S_RECV_LO;
      S_RECV_LO:  if (w_handshake) w_next_state = S_WR_SETUP;
      S_WR_SETUP: w_next_state = S_WR_PULSE;
      S_WR_PULSE: w_next_state = S_WR_HOLD;
      S_WR_HOLD:  w_next_state = w_last_word ? S_DONE : S_RECV_HI;
      S_DONE:     w_next_state = S_IDLE;
      default:    w_next_state = S_IDLE;
    endcase
  end

  // Strobes are registered from the next state so each output lines up with the state it belongs to.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= S_IDLE;
      r_byte_ready <= 1'b0;
      r_we_n       <= 1'b1;
      r_ce_n       <= 1'b1;
      r_oe_n       <= 1'b1;
      r_lb_n       <= 1'b1;
      r_ub_n       <= 1'b1;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_word_count <= '0;
    end else begin
      r_state      <= w_next_state;
      r_byte_ready <= (w_next_state inside {S_RECV_HI, S_RECV_LO});
      r_ce_n       <= !(w_next_state inside {S_WR_SETUP, S_WR_PULSE, S_WR_HOLD});
      r_lb_n       <= !(w_next_state inside {S_WR_SETUP, S_WR_PULSE, S_WR_HOLD});
      r_ub_n       <= !(w_next_state inside {S_WR_SETUP, S_WR_PULSE, S_WR_HOLD});
      r_we_n       <= (w_next_state != S_WR_PULSE);
      r_oe_n       <= 1'b1;
      r_busy       <= !(w_next_state inside {S_IDLE, S_DONE});

      if (r_state == S_IDLE && i_start) begin
        r_addr       <= START_A;
        r_word_count <= '0;
        r_done       <= 1'b0;
      end
      if (w_next_state == S_DONE) r_done <= 1'b1;

      if (r_state == S_RECV_HI && w_handshake) r_wdata[15:8] <= i_byte;
      if (r_state == S_RECV_LO && w_handshake) r_wdata[7:0]  <= i_byte;

      // The address stops on the last word so it never leaves the loaded region.
      if (r_state == S_WR_HOLD) begin
        r_word_count <= r_word_count + 1'b1;
        if (!w_last_word) r_addr <= r_addr + 1'b1;
      end
    end
  end

`ifdef LOADER_CHECKSUM_EN
  logic [15:0] r_checksum;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_checksum <= '0;
    end else if (r_state == S_IDLE && i_start) begin
      r_checksum <= '0;
    end else if (r_state == S_WR_HOLD) begin
      r_checksum <= r_checksum + r_wdata[15:0];
    end
  end

  assign o_checksum = r_checksum;
`else
  assign o_checksum = '0;
`endif

  assign o_byte_ready = r_byte_ready;
  assign o_sram_addr  = r_addr;
  assign o_sram_wdata = r_wdata;
  assign o_sram_we_n  = r_we_n;
  assign o_sram_ce_n  = r_ce_n;
  assign o_sram_oe_n  = r_oe_n;
  assign o_sram_lb_n  = r_lb_n;
  assign o_sram_ub_n  = r_ub_n;
  assign o_busy       = r_busy;
  assign o_done       = r_done;
  assign o_word_count = r_word_count;
  assign o_dbg_state  = r_state;

endmodule

// File: tb/tb_sram_image_loader.sv
// Bench for sram_image_loader: byte driver, SRAM write monitor with expected-word queue, summary.
// Expected words come from plain byte-pair arithmetic over the bytes each load sends.
module tb_sram_image_loader;

  localparam int AW = 20;
  localparam int DW = 16;
  localparam int SA = 'h10;
  localparam int LW = 4;

  logic          i_clk = 1'b0;
  logic          i_rst;
  logic          i_start;
  logic          i_byte_valid;
  logic [7:0]    i_byte;
  logic          o_byte_ready;
  logic [AW-1:0] o_sram_addr;
  logic [DW-1:0] o_sram_wdata;
  logic          o_sram_we_n;
  logic          o_sram_ce_n;
  logic          o_sram_oe_n;
  logic          o_sram_lb_n;
  logic          o_sram_ub_n;
  logic          o_busy;
  logic          o_done;
  logic [AW-1:0] o_word_count;
  logic [15:0]   o_checksum;
  logic [2:0]    o_dbg_state;

  sram_image_loader #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .START_ADDR(SA), .LOAD_WORDS(LW)
  ) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start),
    .i_byte_valid(i_byte_valid), .i_byte(i_byte), .o_byte_ready(o_byte_ready),
    .o_sram_addr(o_sram_addr), .o_sram_wdata(o_sram_wdata),
    .o_sram_we_n(o_sram_we_n), .o_sram_ce_n(o_sram_ce_n), .o_sram_oe_n(o_sram_oe_n),
    .o_sram_lb_n(o_sram_lb_n), .o_sram_ub_n(o_sram_ub_n),
    .o_busy(o_busy), .o_done(o_done), .o_word_count(o_word_count),
    .o_checksum(o_checksum), .o_dbg_state(o_dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 i_clk = ~i_clk;

  int cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [AW+DW-1:0] exp_q[$];
  logic [7:0]       tx_q[$];
  int               mode = 0;
  logic             check_period = 1'b0;
  int               last_we_cyc = -1;
  logic [15:0]      exp_sum;
  logic [7:0]       basic_b [8] = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0};
  logic [7:0]       rand_b [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- monitor ----------------
  logic          prev_we_n = 1'b1;
  logic          prev_ce_n = 1'b1;
  logic [AW-1:0] prev_addr = '0;
  logic [DW-1:0] prev_data = '0;
  logic          post_pending = 1'b0;

  always @(negedge i_clk) begin
    logic [AW+DW-1:0] e;
    if (!i_rst) begin
      if (post_pending) begin
        check("hold_we_n", o_sram_we_n, 1);
        check("hold_ce_n", o_sram_ce_n, 0);
        check("hold_addr", o_sram_addr, prev_addr);
        check("hold_data", o_sram_wdata, prev_data);
        post_pending = 1'b0;
      end
      if (!o_sram_ce_n) check("ready_low_in_write", o_byte_ready, 0);
      if (!o_sram_we_n) begin
        check("setup_we_n", prev_we_n, 1);
        check("setup_ce_n", prev_ce_n, 0);
        check("setup_addr", prev_addr, o_sram_addr);
        check("setup_data", prev_data, o_sram_wdata);
        check("wr_oe_n", o_sram_oe_n, 1);
        check("wr_lb_ub_n", {o_sram_lb_n, o_sram_ub_n}, 0);
        check("write_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("wr_addr", o_sram_addr, e[AW+DW-1:DW]);
          check("wr_data", o_sram_wdata, e[DW-1:0]);
        end
        if (check_period && last_we_cyc >= 0) check("word_period", cyc - last_we_cyc, 5);
        last_we_cyc  = cyc;
        post_pending = 1'b1;
      end
    end else begin
      post_pending = 1'b0;
    end
    prev_we_n = o_sram_we_n;
    prev_ce_n = o_sram_ce_n;
    prev_addr = o_sram_addr;
    prev_data = o_sram_wdata;
  end

  // ---------------- driver tasks ----------------
  task automatic drive_bytes(input int budget);
    int   n = 0;
    logic pending = 1'b0;
    while ((tx_q.size() > 0 || pending) && n < budget) begin
      @(negedge i_clk);
      n++;
      if (pending) begin
        void'(tx_q.pop_front());
        i_byte_valid = 1'b0;
        pending = 1'b0;
      end
      if (!i_byte_valid && tx_q.size() > 0) begin
        if (mode == 0 || (mode == 1 && cyc % 7 == 0) ||
            (mode == 2 && $urandom_range(0, 2) != 0)) begin
          i_byte_valid = 1'b1;
          i_byte = tx_q[0];
        end
      end
      if (i_byte_valid && o_byte_ready) pending = 1'b1;
    end
    check("driver_drained", tx_q.size(), 0);
    i_byte_valid = 1'b0;
    tx_q.delete();
  endtask

  task automatic pulse_start();
    @(negedge i_clk);
    i_start = 1'b1;
    @(negedge i_clk);
    i_start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (!o_done && n < budget) begin
      @(negedge i_clk);
      n++;
    end
    check("done_seen", o_done, 1);
  endtask

  // Reference model: word i is byte 2i then byte 2i+1, written at START+i.
  task automatic prep(input int m, input logic [7:0] b [8]);
    logic [15:0] w;
    mode = m;
    check_period = (m == 0);
    last_we_cyc = -1;
    exp_sum = '0;
    for (int i = 0; i < LW; i++) begin
      w = {b[2*i], b[2*i+1]};
      exp_q.push_back({AW'(SA + i), w});
      exp_sum = exp_sum + w;
    end
    for (int i = 0; i < 2*LW; i++) tx_q.push_back(b[i]);
  endtask

  task automatic check_started();
    check("start_busy", o_busy, 1);
    check("start_done_clr", o_done, 0);
    check("start_addr", o_sram_addr, SA);
    check("start_count", o_word_count, 0);
    check("start_ready", o_byte_ready, 1);
  endtask

  task automatic check_end();
    check("end_done", o_done, 1);
    check("end_busy", o_busy, 0);
    check("end_count", o_word_count, LW);
    check("end_addr", o_sram_addr, SA + LW - 1);
    check("end_ce_n", o_sram_ce_n, 1);
    check("end_exp_q_empty", exp_q.size(), 0);
`ifdef LOADER_CHECKSUM_EN
    check("end_checksum", o_checksum, exp_sum);
`else
    check("end_checksum", o_checksum, 16'h0);
`endif
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int n;
    i_rst = 1'b1; i_start = 1'b0; i_byte_valid = 1'b0; i_byte = 8'h00;
    repeat (3) @(negedge i_clk);
    check("rst_ready", o_byte_ready, 0);
    check("rst_busy", o_busy, 0);
    check("rst_done", o_done, 0);
    check("rst_addr", o_sram_addr, 0);
    check("rst_wdata", o_sram_wdata, 0);
    check("rst_count", o_word_count, 0);
    check("rst_checksum", o_checksum, 0);
    check("rst_we_n", o_sram_we_n, 1);
    check("rst_ce_n", o_sram_ce_n, 1);
    check("rst_oe_n", o_sram_oe_n, 1);
    check("rst_lb_n", o_sram_lb_n, 1);
    check("rst_ub_n", o_sram_ub_n, 1);
    i_rst = 1'b0;

    // Basic load with continuous valid (also exercises backpressure in write states).
    prep(0, basic_b);
    pulse_start();
    check_started();
    drive_bytes(500);
    wait_done(200);
    check_end();

    // Start in the DONE cycle is ignored.
    i_start = 1'b1;
    @(negedge i_clk);
    i_start = 1'b0;
    check("done_cycle_start_busy", o_busy, 0);
    check("done_cycle_start_done", o_done, 1);

    // Sparse source; start from IDLE clears o_done.
    prep(1, basic_b);
    pulse_start();
    check_started();
    drive_bytes(2000);
    wait_done(200);
    check_end();

    // Random bytes, random valid gaps.
    for (int i = 0; i < 8; i++) rand_b[i] = 8'($urandom_range(0, 255));
    prep(2, rand_b);
    pulse_start();
    check_started();
    drive_bytes(2000);
    wait_done(200);
    check_end();

    // Start pulsed mid-load must not restart the load.
    for (int i = 0; i < 8; i++) rand_b[i] = 8'($urandom_range(0, 255));
    prep(2, rand_b);
    pulse_start();
    check_started();
    fork
      drive_bytes(2000);
      begin
        n = 0;
        while (exp_q.size() > 2 && n < 2000) begin
          @(negedge i_clk);
          n++;
        end
        i_start = 1'b1;
        @(negedge i_clk);
        i_start = 1'b0;
        check("midload_busy", o_busy, 1);
      end
    join
    wait_done(200);
    check_end();

    // Reset after the first byte of the second word.
    mode = 0;
    check_period = 1'b1;
    last_we_cyc = -1;
    exp_q.push_back({AW'(SA), {basic_b[0], basic_b[1]}});
    for (int i = 0; i < 3; i++) tx_q.push_back(basic_b[i]);
    pulse_start();
    drive_bytes(500);
    repeat (2) @(negedge i_clk);
    check("prerst_exp_q_empty", exp_q.size(), 0);
    check("prerst_count", o_word_count, 1);
    i_rst = 1'b1;
    @(negedge i_clk);
    check("midrst_we_n", o_sram_we_n, 1);
    check("midrst_ce_n", o_sram_ce_n, 1);
    check("midrst_busy", o_busy, 0);
    check("midrst_count", o_word_count, 0);
    check("midrst_ready", o_byte_ready, 0);
    i_rst = 1'b0;

    prep(0, basic_b);
    pulse_start();
    check_started();
    drive_bytes(500);
    wait_done(200);
    check_end();

    repeat (3) @(negedge i_clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
